// File: rtl/tablero_pkg.sv
// Shared constants for the dashboard ("tablero") panel.
// Holds the board clock rate, the switch-vector bit map and the default
// debounce timing used by switch_debouncer.
package tablero_pkg;

  localparam int unsigned CLK_HZ    = 50_000_000;

  localparam int unsigned NUM_DOORS = 4;
  localparam int unsigned NUM_BELTS = 2;

  // Bit positions inside the switch state vector
  localparam int unsigned DOOR_FL   = 0;
  localparam int unsigned DOOR_FR   = 1;
  localparam int unsigned DOOR_RL   = 2;
  localparam int unsigned DOOR_RR   = 3;
  localparam int unsigned BELT_DRV  = 4;
  localparam int unsigned BELT_PAS  = 5;

  // 1 kHz debounce tick at the board clock, 10 ms acceptance window
  localparam int unsigned DEFAULT_TICK_DIV     = CLK_HZ / 1000;
  localparam int unsigned DEFAULT_STABLE_TICKS = 10;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/switch_debouncer_channel.sv
// debounce_channel: one switch bit.
// Two-flop synchroniser, consecutive-tick stability counter, debounced
// state bit and registered one-cycle rise/fall event pulses.
// Ports:
//   clock   - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   raw     - raw switch level, asynchronous to clock
//   tick    - shared prescaler tick, one cycle wide
//   state   - debounced level
//   rise    - one-cycle pulse when state goes 0->1
//   fall    - one-cycle pulse when state goes 1->0
module debounce_channel
  import tablero_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  input  logic tick,
  output logic state,
  output logic rise,
  output logic fall
);

  localparam int unsigned   CW   = cnt_width(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic          sync_meta;
  logic          sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      cnt       <= '0;
      state     <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
      rise      <= 1'b0;
      fall      <= 1'b0;
      if (sync == state) begin
        // Any return to the accepted level restarts the stability count
        cnt <= '0;
      end else if (tick) begin
        if (cnt == LAST) begin
          state <= sync;
          cnt   <= '0;
          rise  <= sync;
          fall  <= ~sync;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: input conditioning for the dashboard switch lines.
// Bits [3:0] are door switches, bits [5:4] seatbelt switches
// (1 = door open / belt unlatched). A free-running prescaler shared by all
// channels produces the debounce tick; each bit is debounced independently.
// Ports:
//   clock   - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   raw_in  - raw switch levels, asynchronous to clock
//   state   - debounced switch levels, registered
//   rise    - per-bit one-cycle pulse on 0->1
//   fall    - per-bit one-cycle pulse on 1->0
//   changed - one-cycle pulse, OR of all rise and fall bits
module switch_debouncer
  import tablero_pkg::*;
#(
  parameter int unsigned WIDTH        = NUM_DOORS + NUM_BELTS,
  parameter int unsigned TICK_DIV     = DEFAULT_TICK_DIV,
  parameter int unsigned STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int unsigned   PW     = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (pre_cnt == P_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_comb begin
    tick = (pre_cnt == P_LAST);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_chan (
      .clock  (clock),
      .reset_n(reset_n),
      .raw    (raw_in[i]),
      .tick   (tick),
      .state  (state[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  // rise/fall are registered, so this pulse lines up with them exactly
  always_comb begin
    changed = |{rise, fall};
  end

endmodule

// File: tb/tb_switch_debouncer.sv
module tb_switch_debouncer;

  localparam int unsigned W = 6;

  logic         clock;
  logic         reset_n;
  logic [W-1:0] raw_in;
  logic [W-1:0] state;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         changed;

  int unsigned total = 0;
  int unsigned bad   = 0;

  int unsigned rise_cnt [W] = '{default: 0};
  int unsigned fall_cnt [W] = '{default: 0};
  int unsigned changed_cnt  = 0;
  int unsigned overlap_cnt  = 0;

  switch_debouncer #(
    .WIDTH       (6),
    .TICK_DIV    (4),
    .STABLE_TICKS(3)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .raw_in (raw_in),
    .state  (state),
    .rise   (rise),
    .fall   (fall),
    .changed(changed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Event monitor, sampled on the inactive edge
  always @(negedge clock) begin
    for (int i = 0; i < W; i++) begin
      if (rise[i] === 1'b1) rise_cnt[i] <= rise_cnt[i] + 1;
      if (fall[i] === 1'b1) fall_cnt[i] <= fall_cnt[i] + 1;
    end
    if (changed === 1'b1) changed_cnt <= changed_cnt + 1;
    if ((rise & fall) !== '0) overlap_cnt <= overlap_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs a fixed number of cycles, recording the first cycle on which state
  // equals want together with the pulses visible on that cycle.
  task automatic wait_for_state(input logic [W-1:0] want, input int unsigned budget,
                                output int unsigned hit, output logic [W-1:0] r,
                                output logic [W-1:0] f, output logic ch);
    hit = 0;
    r   = '0;
    f   = '0;
    ch  = 1'b0;
    for (int n = 1; n <= int'(budget); n++) begin
      step();
      if (hit == 0 && state === want) begin
        hit = n;
        r   = rise;
        f   = fall;
        ch  = changed;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    raw_in  = '0;
    for (int n = 0; n < 3; n++) step();
    total++;
    if (state !== 6'b000000 || rise !== 6'b000000 || fall !== 6'b000000 || changed !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got state=%b rise=%b fall=%b changed=%b want all 0",
               state, rise, fall, changed);
    end
    reset_n = 1'b1;
    step();
    total++;
    if (state !== 6'b000000 || changed !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got state=%b changed=%b want 000000/0", state, changed);
    end
  endtask

  task automatic test_clean_press();
    int unsigned hit, c0, r0, f0;
    logic [W-1:0] r, f;
    logic ch;
    c0 = changed_cnt; r0 = rise_cnt[0]; f0 = fall_cnt[0];
    raw_in = 6'b000001;
    wait_for_state(6'b000001, 20, hit, r, f, ch);
    total++;
    if (hit < 11 || hit > 14) begin
      bad++;
      $display("FAIL press_latency: got %0d cycles want 11..14", hit);
    end
    total++;
    if (r !== 6'b000001 || f !== 6'b000000 || ch !== 1'b1) begin
      bad++;
      $display("FAIL press_pulse: got rise=%b fall=%b changed=%b want 000001/000000/1", r, f, ch);
    end
    total++;
    if (rise_cnt[0] - r0 != 1 || fall_cnt[0] - f0 != 0 || changed_cnt - c0 != 1) begin
      bad++;
      $display("FAIL press_counts: got rise=%0d fall=%0d changed=%0d want 1/0/1",
               rise_cnt[0] - r0, fall_cnt[0] - f0, changed_cnt - c0);
    end
  endtask

  task automatic test_release();
    int unsigned hit, c0, r0, f0;
    logic [W-1:0] r, f;
    logic ch;
    c0 = changed_cnt; r0 = rise_cnt[0]; f0 = fall_cnt[0];
    raw_in = 6'b000000;
    wait_for_state(6'b000000, 20, hit, r, f, ch);
    total++;
    if (hit < 11 || hit > 14) begin
      bad++;
      $display("FAIL release_latency: got %0d cycles want 11..14", hit);
    end
    total++;
    if (f !== 6'b000001 || r !== 6'b000000 || ch !== 1'b1) begin
      bad++;
      $display("FAIL release_pulse: got rise=%b fall=%b changed=%b want 000000/000001/1", r, f, ch);
    end
    total++;
    if (fall_cnt[0] - f0 != 1 || rise_cnt[0] - r0 != 0 || changed_cnt - c0 != 1) begin
      bad++;
      $display("FAIL release_counts: got fall=%0d rise=%0d changed=%0d want 1/0/1",
               fall_cnt[0] - f0, rise_cnt[0] - r0, changed_cnt - c0);
    end
  endtask

  task automatic test_bounce();
    int unsigned hit, c0;
    logic [W-1:0] r, f;
    logic ch;
    c0 = changed_cnt;
    for (int seg = 1; seg <= 20; seg++) begin
      raw_in[2] = (seg % 2 == 1) ? 1'b1 : 1'b0;
      step();
      step();
    end
    total++;
    if (changed_cnt - c0 != 0 || state !== 6'b000000) begin
      bad++;
      $display("FAIL bounce_reject: got changed=%0d state=%b want 0/000000", changed_cnt - c0, state);
    end
    raw_in[2] = 1'b1;
    wait_for_state(6'b000100, 20, hit, r, f, ch);
    total++;
    if (hit < 11 || hit > 14) begin
      bad++;
      $display("FAIL bounce_latency: got %0d cycles want 11..14", hit);
    end
    total++;
    if (r !== 6'b000100 || ch !== 1'b1) begin
      bad++;
      $display("FAIL bounce_pulse: got rise=%b changed=%b want 000100/1", r, ch);
    end
  endtask

  task automatic test_glitch();
    int unsigned c0, r0;
    c0 = changed_cnt; r0 = rise_cnt[4];
    raw_in[4] = 1'b1;
    for (int n = 0; n < 7; n++) step();
    raw_in[4] = 1'b0;
    for (int n = 0; n < 25; n++) step();
    total++;
    if (state !== 6'b000100 || changed_cnt - c0 != 0 || rise_cnt[4] - r0 != 0) begin
      bad++;
      $display("FAIL glitch_reject: got state=%b changed=%0d rise4=%0d want 000100/0/0",
               state, changed_cnt - c0, rise_cnt[4] - r0);
    end
  endtask

  task automatic test_simultaneous();
    int unsigned hit, c0;
    int unsigned r0 [W];
    logic [W-1:0] r, f;
    logic ch;
    raw_in = 6'b000000;
    for (int n = 0; n < 20; n++) step();
    total++;
    if (state !== 6'b000000) begin
      bad++;
      $display("FAIL simul_precondition: got state=%b want 000000", state);
    end
    c0 = changed_cnt;
    for (int i = 0; i < W; i++) r0[i] = rise_cnt[i];
    raw_in = 6'b110011;
    wait_for_state(6'b110011, 20, hit, r, f, ch);
    total++;
    if (hit < 11 || hit > 14) begin
      bad++;
      $display("FAIL simul_latency: got %0d cycles want 11..14", hit);
    end
    total++;
    if (r !== 6'b110011 || f !== 6'b000000 || ch !== 1'b1) begin
      bad++;
      $display("FAIL simul_pulse: got rise=%b fall=%b changed=%b want 110011/000000/1", r, f, ch);
    end
    total++;
    if (changed_cnt - c0 != 1) begin
      bad++;
      $display("FAIL simul_changed_count: got %0d want 1", changed_cnt - c0);
    end
    for (int i = 0; i < W; i++) begin
      total++;
      if (rise_cnt[i] - r0[i] != ((i == 0 || i == 1 || i == 4 || i == 5) ? 1 : 0)) begin
        bad++;
        $display("FAIL simul_rise_count[%0d]: got %0d want %0d", i, rise_cnt[i] - r0[i],
                 (i == 0 || i == 1 || i == 4 || i == 5) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    int unsigned hit, f0, c0;
    int unsigned fsum;
    logic [W-1:0] r, f;
    logic ch;
    raw_in = 6'b110001;
    for (int n = 0; n < 20; n++) step();
    total++;
    if (state !== 6'b110001) begin
      bad++;
      $display("FAIL midrst_precondition: got state=%b want 110001", state);
    end
    raw_in = 6'b110011;
    for (int n = 0; n < 6; n++) step();
    fsum = 0;
    for (int i = 0; i < W; i++) fsum += fall_cnt[i];
    f0 = fsum;
    c0 = changed_cnt;
    #3;
    reset_n = 1'b0;
    #1;
    total++;
    if (state !== 6'b000000 || rise !== 6'b000000 || fall !== 6'b000000 || changed !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async_clear: got state=%b rise=%b fall=%b changed=%b want all 0",
               state, rise, fall, changed);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    wait_for_state(6'b110011, 20, hit, r, f, ch);
    total++;
    if (hit != 12) begin
      bad++;
      $display("FAIL midrst_fresh_count: got %0d cycles want 12", hit);
    end
    total++;
    if (r !== 6'b110011 || ch !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pulse: got rise=%b changed=%b want 110011/1", r, ch);
    end
    fsum = 0;
    for (int i = 0; i < W; i++) fsum += fall_cnt[i];
    total++;
    if (fsum - f0 != 0 || changed_cnt - c0 != 1) begin
      bad++;
      $display("FAIL midrst_no_event: got fall=%0d changed=%0d want 0/1", fsum - f0, changed_cnt - c0);
    end
  endtask

  task automatic test_exclusive();
    total++;
    if (overlap_cnt != 0) begin
      bad++;
      $display("FAIL rise_fall_exclusive: got %0d overlapping cycles want 0", overlap_cnt);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    raw_in  = '0;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid_count();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
